// File: rtl/f2i_pkg.sv
// Shared types for the pipelined float-to-integer converter: rounding modes,
// operand classes and the per-result exception flags.
package f2i_pkg;

    typedef enum logic [1:0] {
        RND_RZ  = 2'd0,
        RND_RNE = 2'd1,
        RND_RUP = 2'd2,
        RND_RDN = 2'd3
    } rnd_mode_e;

    typedef enum logic [2:0] {
        ZERO,
        SUB,
        NORM,
        INF,
        NAN
    } fp_class_e;

    typedef struct packed {
        logic p_lost;
        logic denorm;
        logic invalid;
    } f2i_flags_t;

    function automatic fp_class_e classify(input logic exp_zero,
                                           input logic exp_ones,
                                           input logic frac_zero);
        if (exp_zero)      return frac_zero ? ZERO : SUB;
        else if (exp_ones) return frac_zero ? INF : NAN;
        else               return NORM;
    endfunction

endpackage

// File: rtl/f2i_if.sv
// Valid/ready bundle between an FP producer, the converter and an integer consumer.
interface f2i_if
    import f2i_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int INT_W  = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [EXP_W+FRAC_W:0]   in_data;
    rnd_mode_e               in_rnd;
    logic                    out_valid;
    logic                    out_ready;
    logic [INT_W-1:0]        out_data;
    logic                    out_p_lost;
    logic                    out_denorm;
    logic                    out_invalid;

    modport master (
        output in_valid, in_data, in_rnd, out_ready,
        input  in_ready, out_valid, out_data, out_p_lost, out_denorm, out_invalid
    );

    modport slave (
        input  in_valid, in_data, in_rnd, out_ready,
        output in_ready, out_valid, out_data, out_p_lost, out_denorm, out_invalid
    );
endinterface

// File: rtl/f2i_round.sv
// Final-stage combinational logic: rounding increment, range check,
// saturation and two's-complement negation of the shifted magnitude.
module f2i_round
    import f2i_pkg::*;
#(
    parameter int INT_W = 32
) (
    input  logic             sign,
    input  fp_class_e        cls,
    input  rnd_mode_e        rnd,
    input  logic [INT_W+1:0] m,
    input  logic             g,
    input  logic             s,
    output logic [INT_W-1:0] data,
    output f2i_flags_t       flags
);
    localparam int MW = INT_W + 2;
    localparam logic [MW-1:0]    MAX_NEG = {{(MW-1){1'b0}}, 1'b1} << (INT_W-1);
    localparam logic [MW-1:0]    MAX_POS = MAX_NEG - MW'(1);
    localparam logic [INT_W-1:0] SAT_POS = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] SAT_NEG = {1'b1, {(INT_W-1){1'b0}}};

    logic             inc;
    logic [MW-1:0]    m_r;
    logic [INT_W-1:0] mag;
    logic             ovf;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        inc = 1'b0;
        unique case (rnd)
            RND_RZ:  inc = 1'b0;
            RND_RNE: inc = g & (s | m[0]);
            RND_RUP: inc = ~sign & (g | s);
            RND_RDN: inc = sign & (g | s);
            default: inc = 1'b0;
        endcase
    end

    assign m_r = m + MW'(inc);
    assign mag = m_r[INT_W-1:0];
    // The negative side reaches one further: exactly -2^(INT_W-1) is representable.
    assign ovf = sign ? (m_r > MAX_NEG) : (m_r > MAX_POS);

    always_comb begin
        data  = '0;
        flags = '0;
        unique case (cls)
            ZERO: ;
            NAN:  flags.invalid = 1'b1;
            INF: begin
                data          = sign ? SAT_NEG : SAT_POS;
                flags.invalid = 1'b1;
            end
            default: begin
                if (ovf) begin
                    data          = sign ? SAT_NEG : SAT_POS;
                    flags.invalid = 1'b1;
                end else begin
                    data         = sign ? -mag : mag;
                    flags.p_lost = g | s;
                    flags.denorm = (cls == SUB);
                end
            end
        endcase
    end

endmodule

// File: rtl/f2i_pipe.sv
// Three-stage floating-point to signed-integer converter with a global
// valid/ready stall: S1 classify/capture, S2 align, S3 round/saturate.
module f2i_pipe
    import f2i_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int INT_W  = 32
) (
    input logic clk,
    input logic rst_n,
    f2i_if.slave bus
);
    localparam int DW     = INT_W + FRAC_W + 3;
    localparam int MW     = INT_W + 2;
    localparam int BIAS   = 2**(EXP_W-1) - 1;
    localparam int MAX_SH = INT_W + 1;

    logic advance;

    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [FRAC_W-1:0] in_frac;
    fp_class_e         in_class;

    logic              s1_valid, s1_sign;
    logic [EXP_W-1:0]  s1_exp;
    logic [FRAC_W-1:0] s1_frac;
    fp_class_e         s1_class;
    rnd_mode_e         s1_rnd;

    int                sh_amt;
    logic [DW-1:0]     shifted;
    logic [MW-1:0]     sh_m;
    logic              sh_g, sh_s;

    logic              s2_valid, s2_sign, s2_g, s2_s;
    fp_class_e         s2_class;
    rnd_mode_e         s2_rnd;
    logic [MW-1:0]     s2_m;

    logic [INT_W-1:0]  rnd_data;
    f2i_flags_t        rnd_flags;

    logic              out_valid_q;
    logic [INT_W-1:0]  out_data_q;
    f2i_flags_t        out_flags_q;

    // A stalled output freezes the whole pipe; bubbles only move when it advances.
    assign advance      = bus.out_ready | ~out_valid_q;
    assign bus.in_ready = advance;

    assign {in_sign, in_exp, in_frac} = bus.in_data;
    assign in_class = classify(in_exp == '0, &in_exp, in_frac == '0);

    // Align {1,frac} so the low FRAC_W+1 bits are the fraction; huge exponents
    // clamp the shift, which still leaves m >= 2^INT_W and trips saturation.
    always_comb begin
        sh_amt  = 0;
        shifted = '0;
        sh_m    = '0;
        sh_g    = 1'b0;
        sh_s    = 1'b0;
        if (s1_class == SUB) begin
            sh_s = 1'b1;
        end else if (s1_class == NORM) begin
            if (int'(s1_exp) < BIAS - 1) begin
                sh_s = 1'b1;
            end else begin
                sh_amt  = int'(s1_exp) - (BIAS - 1);
                if (sh_amt > MAX_SH) sh_amt = MAX_SH;
                shifted = DW'({1'b1, s1_frac}) << sh_amt;
                sh_m    = shifted[DW-1 -: MW];
                sh_g    = shifted[FRAC_W];
                sh_s    = |shifted[FRAC_W-1:0];
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every stage samples the pre-edge value of the one before it.
    // NOTE: data registers are reset along with the valids so outputs read a defined zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_exp      <= '0;
            s1_frac     <= '0;
            s1_class    <= ZERO;
            s1_rnd      <= RND_RZ;
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_class    <= ZERO;
            s2_rnd      <= RND_RZ;
            s2_m        <= '0;
            s2_g        <= 1'b0;
            s2_s        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else if (advance) begin
            s1_valid    <= bus.in_valid;
            s1_sign     <= in_sign;
            s1_exp      <= in_exp;
            s1_frac     <= in_frac;
            s1_class    <= in_class;
            s1_rnd      <= bus.in_rnd;
            s2_valid    <= s1_valid;
            s2_sign     <= s1_sign;
            s2_class    <= s1_class;
            s2_rnd      <= s1_rnd;
            s2_m        <= sh_m;
            s2_g        <= sh_g;
            s2_s        <= sh_s;
            out_valid_q <= s2_valid;
            out_data_q  <= rnd_data;
            out_flags_q <= rnd_flags;
        end
    end

    f2i_round #(.INT_W(INT_W)) u_round (
        .sign  (s2_sign),
        .cls   (s2_class),
        .rnd   (s2_rnd),
        .m     (s2_m),
        .g     (s2_g),
        .s     (s2_s),
        .data  (rnd_data),
        .flags (rnd_flags)
    );

    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_p_lost  = out_flags_q.p_lost;
    assign bus.out_denorm  = out_flags_q.denorm;
    assign bus.out_invalid = out_flags_q.invalid;

endmodule
